branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the IF stage of the next-generation 5-stage pipelined core.
- Provides a same-cycle taken/target prediction for the fetch PC, so that fetch no longer assumes fall-through.
- Contains a direct-mapped BTB plus a 2-bit-counter PHT, indexed in bimodal or gshare mode.
- Trained non-speculatively by the EX-stage branch resolution port; also keeps saturating performance counters.

Parameters:
- XLEN, 32, address/data width
- BTB_IDX_BITS, 5, log2 of BTB entries; index = pc[BTB_IDX_BITS+1:2]; tag = pc[XLEN-1:BTB_IDX_BITS+2]
- PHT_IDX_BITS, 5, log2 of PHT entries; also the BHR width
- MODE, 2, prediction mode: 0 = static not-taken, 1 = bimodal, 2 = gshare
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- if_pc  in  XLEN  current fetch PC
- pred_taken  out  1  prediction for if_pc
- pred_target  out  XLEN  predicted target; valid when pred_taken=1
- next_pc  out  XLEN  pred_taken ? pred_target : if_pc+4
- pred_idx  out  PHT_IDX_BITS  PHT index used; carried down the pipeline
- upd_valid  in  1  EX resolution valid this cycle
- upd_pc  in  XLEN  PC of the resolved instruction
- upd_idx  in  PHT_IDX_BITS  pred_idx carried with that instruction
- upd_is_branch  in  1  conditional branch
- upd_is_jump  in  1  JAL/JALR
- upd_taken  in  1  actual direction (1 for jumps)
- upd_target  in  XLEN  actual target
- upd_mispredict  in  1  EX detected a PC mispredict
- br_count  out  CNT_W  resolved branches and jumps
- mispred_count  out  CNT_W  mispredicts

Behaviour:
- Clock clk; reset reset, synchronous, active-high.
- Reset: all BTB valid bits=0; all PHT entries=2'b01 (weakly not-taken); BHR=0; br_count=0; mispred_count=0.
- Reset overrides upd_valid on the same edge.
- Reset mid-operation discards all learned state; after release, outputs become pred_taken=0 and next_pc=if_pc+4.
- Lookup: purely combinational from if_pc, zero latency.
  - hit = valid[bi] && tag[bi]==if_pc tag.
  - PHT index: MODE 1 uses pc[PHT_IDX_BITS+1:2]; MODE 2 uses pc[PHT_IDX_BITS+1:2] ^ BHR.
  - pred_taken = hit && (jump_bit[bi] || pht[pred_idx][1]).
  - MODE 0: pred_taken=0 always and no table writes; pred_idx is still driven.
- Update: on the posedge with upd_valid=1 and reset=0, only if upd_is_branch or upd_is_jump; otherwise it is ignored.
  - Conditional branch, PHT: pht[upd_idx] increments on taken and decrements on not-taken, saturating at 2'b11 and 2'b00.
  - Conditional branch, BHR (MODE 2 only): BHR <= {BHR[PHT_IDX_BITS-2:0], upd_taken}.
  - Any taken branch or jump: BTB[upd bi] <= {valid=1, tag, upd_target, jump_bit=upd_is_jump}. A conflicting entry is overwritten.
  - Not-taken branch: no BTB allocation; an existing entry is retained.
  - Jumps never touch the PHT or BHR.
- Counters:
  - br_count += 1 for each accepted update.
  - mispred_count += 1 when upd_mispredict is also set.
  - Both saturate at all-ones; no wrap.
- Same-cycle read and write of the same entry: lookup sees the old contents. The write is visible next cycle; there is no bypass.
- BHR is updated only at resolution (non-speculative). upd_idx is used as given and is never recomputed.
- The halt/ecall path is unaffected. The pipeline flushes on upd_mispredict outside this block.

Decomposition:
- Shared package bp_pkg holds:
  - mode constants BP_STATIC=0, BP_BIMODAL=1, BP_GSHARE=2
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11
  - the saturating 2-bit increment/decrement function
- One natural sub-module, branch_target_buffer:
  - direct-mapped array with tag/target/jump_bit storage
  - combinational read port and synchronous write port
- PHT, BHR and the counters stay in branch_predictor.

Test Plan:
- Reset, then if_pc=0x40 → pred_taken=0, next_pc=0x44, br_count=0, mispred_count=0.
- MODE=1: resolve a taken branch at 0x40, target 0x10, twice → after the first edge, lookup 0x40 gives pred_taken=1 (01→10) and pred_target=0x10. After three not-taken updates the counter reaches 00, pred_taken=0, and the BTB entry stays valid.
- JAL at 0x80, target 0x200, taken → next cycle, lookup 0x80 gives pred_taken=1 and next_pc=0x200 regardless of the PHT. A taken branch at 0x80+(32<<2)=0x100 evicts it; lookup 0x80 then gives pred_taken=0 (tag mismatch).
- MODE=2: alternating T/NT pattern at 0x40 over 20 iterations, driving upd_idx from pred_idx → after warm-up, predictions match the actual outcome and mispred_count stops incrementing.
- Update and lookup of the same PC in the same cycle → lookup returns the pre-update prediction; the next cycle reflects the update.
- Force 2^CNT_W-1 with CNT_W=4: 20 mispredicted updates → both counters hold at 15. Assert reset together with upd_valid=1 → all state and counters are cleared and the update is discarded.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: mode constants and 2-bit counter helpers.
package bp_pkg;

  localparam int BP_STATIC  = 0;
  localparam int BP_BIMODAL = 1;
  localparam int BP_GSHARE  = 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Saturating step toward the resolved direction.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken) return (c == ST)  ? ST  : ctr_t'(c + 2'd1);
    else       return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup, synchronous write; a write to an occupied slot overwrites it.
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] i_rd_pc,
  output logic            o_rd_hit,
  output logic [XLEN-1:0] o_rd_target,
  output logic            o_rd_jump,
  input  logic            i_wr_en,
  input  logic [XLEN-1:0] i_wr_pc,
  input  logic [XLEN-1:0] i_wr_target,
  input  logic            i_wr_jump
);

  localparam int N     = 1 << IDX_BITS;
  localparam int TAG_W = XLEN - IDX_BITS - 2;

  logic [N-1:0]      r_valid;
  logic [N-1:0]      r_jump;
  logic [TAG_W-1:0]  r_tag    [N];
  logic [XLEN-1:0]   r_target [N];

  logic [IDX_BITS-1:0] w_rd_idx;
  logic [IDX_BITS-1:0] w_wr_idx;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [TAG_W-1:0]    w_wr_tag;
  logic                w_unused_pc_lsbs;

  assign w_rd_idx = i_rd_pc[IDX_BITS+1:2];
  assign w_wr_idx = i_wr_pc[IDX_BITS+1:2];
  assign w_rd_tag = i_rd_pc[XLEN-1:IDX_BITS+2];
  assign w_wr_tag = i_wr_pc[XLEN-1:IDX_BITS+2];
  assign w_unused_pc_lsbs = ^{i_rd_pc[1:0], i_wr_pc[1:0]};

  assign o_rd_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_rd_target = r_target[w_rd_idx];
  assign o_rd_jump   = r_jump[w_rd_idx];

  // Only the valid bits need clearing; tag/target are qualified by them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[w_wr_idx]  <= 1'b1;
      r_jump[w_wr_idx]   <= i_wr_jump;
      r_tag[w_wr_idx]    <= w_wr_tag;
      r_target[w_wr_idx] <= i_wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage predictor: BTB plus 2-bit PHT (bimodal or gshare), zero-latency lookup,
// trained non-speculatively from EX resolution, with saturating perf counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BTB_IDX_BITS = 5,
  parameter int PHT_IDX_BITS = 5,
  parameter int MODE         = 2,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [XLEN-1:0]         if_pc,
  output logic                    pred_taken,
  output logic [XLEN-1:0]         pred_target,
  output logic [XLEN-1:0]         next_pc,
  output logic [PHT_IDX_BITS-1:0] pred_idx,
  input  logic                    upd_valid,
  input  logic [XLEN-1:0]         upd_pc,
  input  logic [PHT_IDX_BITS-1:0] upd_idx,
  input  logic                    upd_is_branch,
  input  logic                    upd_is_jump,
  input  logic                    upd_taken,
  input  logic [XLEN-1:0]         upd_target,
  input  logic                    upd_mispredict,
  output logic [CNT_W-1:0]        br_count,
  output logic [CNT_W-1:0]        mispred_count
);

  localparam int PHT_N = 1 << PHT_IDX_BITS;
  localparam bit DYNAMIC = (MODE != BP_STATIC);

  ctr_t                    r_pht [PHT_N];
  logic [PHT_IDX_BITS-1:0] r_bhr;
  logic [CNT_W-1:0]        r_br_cnt;
  logic [CNT_W-1:0]        r_mp_cnt;

  logic                    w_hit;
  logic                    w_jump;
  logic [XLEN-1:0]         w_target;
  logic [PHT_IDX_BITS-1:0] w_pc_idx;
  logic [PHT_IDX_BITS-1:0] w_pht_idx;
  logic                    w_upd_acc;
  logic                    w_pht_upd;
  logic                    w_btb_wr;

  assign w_pc_idx  = if_pc[PHT_IDX_BITS+1:2];
  assign w_pht_idx = (MODE == BP_GSHARE) ? (w_pc_idx ^ r_bhr) : w_pc_idx;

  assign pred_idx    = w_pht_idx;
  assign pred_taken  = DYNAMIC && w_hit && (w_jump || r_pht[w_pht_idx][1]);
  assign pred_target = w_target;
  assign next_pc     = pred_taken ? w_target : (if_pc + XLEN'(4));

  // Updates carrying neither branch nor jump flag are not control flow and are dropped.
  assign w_upd_acc = upd_valid && (upd_is_branch || upd_is_jump);
  assign w_pht_upd = DYNAMIC && w_upd_acc && upd_is_branch && !upd_is_jump;
  assign w_btb_wr  = DYNAMIC && w_upd_acc && (upd_is_jump || upd_taken);

  branch_target_buffer #(
    .XLEN     (XLEN),
    .IDX_BITS (BTB_IDX_BITS)
  ) u_btb (
    .clk         (clk),
    .reset       (reset),
    .i_rd_pc     (if_pc),
    .o_rd_hit    (w_hit),
    .o_rd_target (w_target),
    .o_rd_jump   (w_jump),
    .i_wr_en     (w_btb_wr),
    .i_wr_pc     (upd_pc),
    .i_wr_target (upd_target),
    .i_wr_jump   (upd_is_jump)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_N; i++) r_pht[i] <= WNT;
      r_bhr <= '0;
    end else if (w_pht_upd) begin
      r_pht[upd_idx] <= ctr_next(r_pht[upd_idx], upd_taken);
      if (MODE == BP_GSHARE) r_bhr <= {r_bhr[PHT_IDX_BITS-2:0], upd_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else if (w_upd_acc) begin
      if (r_br_cnt != '1)                   r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (upd_mispredict && r_mp_cnt != '1) r_mp_cnt <= r_mp_cnt + CNT_W'(1);
    end
  end

  assign br_count      = r_br_cnt;
  assign mispred_count = r_mp_cnt;

endmodule
